generate_descriptor_mc: RTL and testbench

Parametrised, multi-class successor of the host-input descriptor generator, sitting in host_input_process/time_sensitive_injection_control between the TSN-tag lookup and the packet buffer writer. It classifies each incoming packet (mapped 0x1800 or standard Ethernet), applies per-class buffer-admission thresholds, and either forwards the packet with one registered cycle of latency plus a 40-bit descriptor or discards it. It adds per-class enable, saturating per-class discard counters, abort detection for truncated packets, and a descriptor for short standard packets.

---
 rtl/generate_descriptor_mc.sv | 236 +++++++++++++++++++++++
 tb/tb_generate_descriptor_mc.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generate_descriptor_mc.sv
// Classifies host packets (mapped 0x1800 / standard), admits or discards per class, emits a 40-bit descriptor.
// Latency: one registered cycle from input byte to ov_data / descriptor strobe.
// Backpressure: none; an i_data_wr gap inside a forwarded packet aborts it, gaps inside a discarded packet are ignored.
module generate_descriptor_mc #(
  parameter int DATA_W    = 9,
  parameter int BUFID_W   = 9,
  parameter int CNT_W     = 32,
  parameter int DESC_BYTE = 13
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [DATA_W-1:0]      iv_data,
  input  logic                   i_data_wr,
  input  logic [47:0]            iv_tsntag,
  input  logic [15:0]            iv_eth_type,
  input  logic [BUFID_W-1:0]     iv_free_bufid_num,
  input  logic [8*BUFID_W-1:0]   iv_class_threshold,
  input  logic [BUFID_W-1:0]     iv_ctrl_threshold,
  input  logic [BUFID_W-1:0]     iv_lp_threshold,
  input  logic [7:0]             iv_class_en,
  input  logic [2:0]             iv_cnt_sel,
  input  logic                   i_cnt_clr,
  output logic [DATA_W-1:0]      ov_data,
  output logic                   o_data_wr,
  output logic                   o_descriptor_valid,
  output logic [39:0]            ov_descriptor,
  output logic [15:0]            ov_eth_type,
  output logic [4:0]             ov_dbufid,
  output logic [CNT_W-1:0]       ov_discard_cnt,
  output logic [CNT_W-1:0]       ov_discard_total,
  output logic [CNT_W-1:0]       ov_abort_cnt,
  output logic                   o_pkt_abort
);

  localparam logic [15:0]      DESC_IDX = 16'(DESC_BYTE);
  localparam logic [39:0]      STD_DESC = {9'b0, 3'd6, 28'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    MAPPED_SECOND = 3'd1,
    MAPPED_OTHER  = 3'd2,
    TRAN_STANDARD = 3'd3,
    DISC          = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         byte_cnt_q, byte_cnt_d;
  logic                desc_done_q, desc_done_d;
  logic [39:0]         desc_hold_q, desc_hold_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                data_wr_q, data_wr_d;
  logic                desc_vld_q, desc_vld_d;
  logic [39:0]         desc_q, desc_d;
  logic [15:0]         eth_q, eth_d;
  logic [4:0]          dbufid_q, dbufid_d;
  logic                abort_q, abort_d;
  logic [CNT_W-1:0]    disc_cnt_q [8];
  logic [CNT_W-1:0]    disc_cnt_d [8];
  logic [CNT_W-1:0]    disc_total_q, disc_total_d;
  logic [CNT_W-1:0]    abort_cnt_q, abort_cnt_d;

  logic                flag, head, is_mapped, is_ctrl, hd_disc;
  logic [2:0]          hd_class;
  logic [BUFID_W-1:0]  cls_thr, hd_thr;
  logic                disc_inc, abort_inc;
  logic                unused_tag;

  // Tag bits that never reach the descriptor or dbufid.
  assign unused_tag = ^{iv_tsntag[44:43], iv_tsntag[14:10], iv_tsntag[4:0]};

  // Saturating counter step; a clear wins but keeps a coincident increment.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic clr);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clr) begin
      nxt = inc ? CNT_ONE : '0;
    end else if (inc && (cur != {CNT_W{1'b1}})) begin
      nxt = cur + CNT_ONE;
    end
    return nxt;
  endfunction

  // Head classification and admission decision, only meaningful in a head cycle.
  always_comb begin
    flag      = iv_data[DATA_W-1];
    head      = i_data_wr && flag;
    is_mapped = (iv_eth_type == 16'h1800);
    is_ctrl   = (iv_eth_type == 16'hff01) || (iv_eth_type == 16'h88f7) ||
                (iv_eth_type == 16'h891d);
    hd_class  = is_mapped ? iv_data[DATA_W-2 -: 3] : 3'd6;
    cls_thr   = '0;
    for (int c = 0; c < 8; c++) begin
      if (hd_class == 3'(c)) cls_thr = iv_class_threshold[c*BUFID_W +: BUFID_W];
    end
    hd_thr    = is_mapped ? cls_thr : (is_ctrl ? iv_ctrl_threshold : iv_lp_threshold);
    hd_disc   = (iv_free_bufid_num == '0) || (iv_free_bufid_num <= hd_thr) ||
                !iv_class_en[hd_class] ||
                (is_mapped && (hd_class == 3'd6) && (iv_free_bufid_num <= iv_ctrl_threshold));
  end

  // Packet state machine: next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    desc_done_d = desc_done_q;
    desc_hold_d = desc_hold_q;
    data_d      = '0;
    data_wr_d   = 1'b0;
    desc_vld_d  = 1'b0;
    desc_d      = '0;
    eth_d       = '0;
    dbufid_d    = '0;
    abort_d     = 1'b0;
    disc_inc    = 1'b0;
    abort_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (head) begin
          if (hd_disc) begin
            disc_inc = 1'b1;
            state_d  = DISC;
          end else begin
            data_wr_d = 1'b1;
            data_d    = iv_data;
            dbufid_d  = iv_tsntag[9:5];
            if (is_mapped) begin
              desc_hold_d = {9'b0, iv_tsntag[47:45], iv_tsntag[42:15]};
              state_d     = MAPPED_SECOND;
            end else begin
              desc_hold_d = STD_DESC;
              byte_cnt_d  = 16'd1;
              desc_done_d = 1'b0;
              state_d     = TRAN_STANDARD;
            end
          end
        end
      end
      MAPPED_SECOND, MAPPED_OTHER, TRAN_STANDARD: begin
        if (!i_data_wr) begin
          abort_d   = 1'b1;
          abort_inc = 1'b1;
          state_d   = IDLE;
        end else begin
          data_wr_d = 1'b1;
          data_d    = iv_data;
          dbufid_d  = dbufid_q;
          if (state_q == MAPPED_SECOND) begin
            if (flag) begin
              // Tail right after the head: too short to carry a descriptor.
              abort_d   = 1'b1;
              abort_inc = 1'b1;
              state_d   = IDLE;
            end else begin
              desc_vld_d = 1'b1;
              desc_d     = desc_hold_q;
              eth_d      = iv_eth_type;
              state_d    = MAPPED_OTHER;
            end
          end else begin
            if ((state_q == TRAN_STANDARD) && !desc_done_q &&
                (flag || (byte_cnt_q == DESC_IDX))) begin
              desc_vld_d  = 1'b1;
              desc_d      = desc_hold_q;
              eth_d       = iv_eth_type;
              desc_done_d = 1'b1;
            end
            if (byte_cnt_q != 16'hffff) byte_cnt_d = byte_cnt_q + 16'd1;
            if (flag) state_d = IDLE;
          end
        end
      end
      DISC: begin
        if (head) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Statistics counters.
  always_comb begin
    for (int c = 0; c < 8; c++) begin
      disc_cnt_d[c] = cnt_next(disc_cnt_q[c], disc_inc && (hd_class == 3'(c)), i_cnt_clr);
    end
    disc_total_d = cnt_next(disc_total_q, disc_inc, i_cnt_clr);
    abort_cnt_d  = cnt_next(abort_cnt_q, abort_inc, i_cnt_clr);
  end

  // State, output and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      desc_done_q  <= 1'b0;
      desc_hold_q  <= '0;
      data_q       <= '0;
      data_wr_q    <= 1'b0;
      desc_vld_q   <= 1'b0;
      desc_q       <= '0;
      eth_q        <= '0;
      dbufid_q     <= '0;
      abort_q      <= 1'b0;
      for (int c = 0; c < 8; c++) disc_cnt_q[c] <= '0;
      disc_total_q <= '0;
      abort_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      desc_done_q  <= desc_done_d;
      desc_hold_q  <= desc_hold_d;
      data_q       <= data_d;
      data_wr_q    <= data_wr_d;
      desc_vld_q   <= desc_vld_d;
      desc_q       <= desc_d;
      eth_q        <= eth_d;
      dbufid_q     <= dbufid_d;
      abort_q      <= abort_d;
      for (int c = 0; c < 8; c++) disc_cnt_q[c] <= disc_cnt_d[c];
      disc_total_q <= disc_total_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  assign ov_data            = data_q;
  assign o_data_wr          = data_wr_q;
  assign o_descriptor_valid = desc_vld_q;
  assign ov_descriptor      = desc_q;
  assign ov_eth_type        = eth_q;
  assign ov_dbufid          = dbufid_q;
  assign o_pkt_abort        = abort_q;
  assign ov_discard_cnt     = disc_cnt_q[iv_cnt_sel];
  assign ov_discard_total   = disc_total_q;
  assign ov_abort_cnt       = abort_cnt_q;

endmodule

// File: tb/tb_generate_descriptor_mc.sv
// Bench for generate_descriptor_mc: packet-level reference model versus per-cycle DUT outputs.
// Latency: expects each byte one cycle later, descriptor on byte 1 (mapped) or min(DESC_BYTE, tail).
// Backpressure: none; gaps abort forwarded packets and are tolerated in discarded ones.
module tb_generate_descriptor_mc;
  localparam int CW   = 4;
  localparam int DB   = 13;
  localparam int MAXC = 128;
  localparam int CMAX = 15;

  typedef struct packed {
    logic        wr;
    logic [8:0]  dat;
    logic        dv;
    logic [39:0] desc;
    logic [15:0] eth;
    logic [4:0]  dbuf;
    logic        abrt;
  } obs_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [8:0]    iv_data = '0;
  logic          i_data_wr = 1'b0;
  logic [47:0]   iv_tsntag = '0;
  logic [15:0]   iv_eth_type = '0;
  logic [8:0]    iv_free_bufid_num = '0;
  logic [71:0]   iv_class_threshold = '0;
  logic [8:0]    iv_ctrl_threshold = '0;
  logic [8:0]    iv_lp_threshold = '0;
  logic [7:0]    iv_class_en = '0;
  logic [2:0]    iv_cnt_sel = '0;
  logic          i_cnt_clr = 1'b0;
  logic [8:0]    ov_data;
  logic          o_data_wr, o_descriptor_valid, o_pkt_abort;
  logic [39:0]   ov_descriptor;
  logic [15:0]   ov_eth_type;
  logic [4:0]    ov_dbufid;
  logic [CW-1:0] ov_discard_cnt, ov_discard_total, ov_abort_cnt;

  always #5 i_clk = ~i_clk;

  generate_descriptor_mc #(.DATA_W(9), .BUFID_W(9), .CNT_W(CW), .DESC_BYTE(DB)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_data(iv_data), .i_data_wr(i_data_wr),
    .iv_tsntag(iv_tsntag), .iv_eth_type(iv_eth_type), .iv_free_bufid_num(iv_free_bufid_num),
    .iv_class_threshold(iv_class_threshold), .iv_ctrl_threshold(iv_ctrl_threshold),
    .iv_lp_threshold(iv_lp_threshold), .iv_class_en(iv_class_en), .iv_cnt_sel(iv_cnt_sel),
    .i_cnt_clr(i_cnt_clr), .ov_data(ov_data), .o_data_wr(o_data_wr),
    .o_descriptor_valid(o_descriptor_valid), .ov_descriptor(ov_descriptor),
    .ov_eth_type(ov_eth_type), .ov_dbufid(ov_dbufid), .ov_discard_cnt(ov_discard_cnt),
    .ov_discard_total(ov_discard_total), .ov_abort_cnt(ov_abort_cnt), .o_pkt_abort(o_pkt_abort)
  );

  int checks = 0;
  int errors = 0;

  obs_t       obs  [MAXC];
  obs_t       expv [MAXC];
  logic       in_wr  [MAXC];
  logic [8:0] in_dat [MAXC];
  int         ncyc;

  bit          p_mapped, p_trunc, p_clr;
  int          p_cls, p_len, p_abort_at, p_idle, p_free;
  logic [47:0] p_tag;
  logic [15:0] p_eth;

  int         m_thr [8];
  int         m_ctrl, m_lp;
  logic [7:0] m_en;
  int         m_disc [8];
  int         m_total, m_abort;

  logic [15:0] eth_tab [4] = '{16'h0800, 16'hff01, 16'h88f7, 16'h891d};

  function automatic obs_t sample();
    return {o_data_wr, ov_data, o_descriptor_valid, ov_descriptor, ov_eth_type, ov_dbufid, o_pkt_abort};
  endfunction

  task automatic apply_cfg();
    for (int c = 0; c < 8; c++) iv_class_threshold[c*9 +: 9] = 9'(m_thr[c]);
    iv_ctrl_threshold = 9'(m_ctrl);
    iv_lp_threshold   = 9'(m_lp);
    iv_class_en       = m_en;
    iv_free_bufid_num = 9'(p_free);
  endtask

  task automatic default_cfg();
    for (int c = 0; c < 8; c++) m_thr[c] = 50;
    m_ctrl = 30;
    m_lp   = 40;
    m_en   = 8'hff;
  endtask

  task automatic model_zero_counters();
    for (int c = 0; c < 8; c++) m_disc[c] = 0;
    m_total = 0;
    m_abort = 0;
  endtask

  // Admission rule of a packet described by the p_* fields.
  function automatic bit model_discard();
    int cls, thr;
    bit ctl;
    cls = p_mapped ? p_cls : 6;
    ctl = (p_eth == 16'hff01) || (p_eth == 16'h88f7) || (p_eth == 16'h891d);
    thr = p_mapped ? m_thr[cls] : (ctl ? m_ctrl : m_lp);
    return (p_free == 0) || (p_free <= thr) || (m_en[cls] == 1'b0) ||
           (p_mapped && cls == 6 && p_free <= m_ctrl);
  endfunction

  // Expected per-cycle outputs for the recorded input sequence, plus counter updates.
  task automatic model_pkt();
    bit          disc, done;
    int          ds, bidx, cls;
    logic [39:0] d;
    disc = model_discard();
    cls  = p_mapped ? p_cls : 6;
    ds   = p_mapped ? 1 : ((p_len - 1 < DB) ? p_len - 1 : DB);
    d    = p_mapped ? {9'b0, p_tag[47:45], p_tag[42:15]} : {9'b0, 3'd6, 28'b0};
    done = 1'b0;
    bidx = 0;
    for (int j = 0; j < ncyc; j++) begin
      expv[j] = '0;
      if (!done) begin
        if (in_wr[j]) begin
          if (!disc) begin
            expv[j].wr   = 1'b1;
            expv[j].dat  = in_dat[j];
            expv[j].dbuf = p_tag[9:5];
            if (bidx == ds) begin
              expv[j].dv   = 1'b1;
              expv[j].desc = d;
              expv[j].eth  = p_eth;
            end
          end
          if (bidx > 0 && in_dat[j][8]) done = 1'b1;
          bidx++;
        end else if (!disc) begin
          expv[j].abrt = 1'b1;
          done = 1'b1;
        end
      end
    end
    if (p_clr) model_zero_counters();
    if (disc) begin
      m_disc[cls] = (m_disc[cls] < CMAX) ? m_disc[cls] + 1 : CMAX;
      m_total     = (m_total < CMAX) ? m_total + 1 : CMAX;
    end else if (p_abort_at > 0 && p_trunc) begin
      m_abort = (m_abort < CMAX) ? m_abort + 1 : CMAX;
    end
  endtask

  // Drives one packet (optional gap/truncation) plus trailing idle cycles, recording inputs and outputs.
  task automatic send_pkt();
    logic [8:0] b;
    int j;
    j = 0;
    iv_tsntag   = p_tag;
    iv_eth_type = p_eth;
    for (int i = 0; i < p_len; i++) begin
      if (p_abort_at > 0 && i == p_abort_at) begin
        i_data_wr = 1'b0;
        iv_data   = 9'($urandom);
        in_wr[j] = 1'b0; in_dat[j] = iv_data;
        @(posedge i_clk); #1;
        obs[j] = sample(); j++;
        if (p_trunc) break;
      end
      b = {(i == 0 || i == p_len - 1), 8'($urandom)};
      if (i == 0 && p_mapped) b[7:5] = 3'(p_cls);
      iv_data   = b;
      i_data_wr = 1'b1;
      i_cnt_clr = (i == 0) && p_clr;
      in_wr[j] = 1'b1; in_dat[j] = b;
      @(posedge i_clk); #1;
      obs[j] = sample(); j++;
      i_cnt_clr = 1'b0;
      if (i == 0) iv_free_bufid_num = 9'($urandom);
    end
    i_data_wr = 1'b0;
    for (int k = 0; k < p_idle; k++) begin
      iv_data = 9'($urandom);
      in_wr[j] = 1'b0; in_dat[j] = iv_data;
      @(posedge i_clk); #1;
      obs[j] = sample(); j++;
    end
    ncyc = j;
  endtask

  task automatic set_pkt(bit mapped, int cls, int len, int free, logic [15:0] eth);
    p_mapped = mapped; p_cls = cls; p_len = len; p_free = free; p_eth = eth;
    p_tag = {16'($urandom), 32'($urandom)};
    p_abort_at = 0; p_trunc = 1'b1; p_clr = 1'b0; p_idle = 1;
  endtask

  task automatic test_reset();
    obs_t o;
    repeat (2) @(posedge i_clk);
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", o); end
    checks++;
    if (ov_discard_total !== '0 || ov_abort_cnt !== '0 || ov_discard_cnt !== '0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", ov_discard_total, ov_abort_cnt, ov_discard_cnt);
    end
    i_rst_n = 1'b1;
    model_zero_counters();
    @(posedge i_clk); #1;
  endtask

  task automatic test_mapped();
    default_cfg();
    set_pkt(1'b1, 3, 64, 100, 16'h1800);
    apply_cfg();
    send_pkt(); model_pkt();
    for (int j = 0; j < ncyc; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin errors++; $display("FAIL mapped_cyc%0d got=%h want=%h", j, obs[j], expv[j]); end
    end
    checks++;
    if (ov_discard_total !== CW'(m_total)) begin errors++; $display("FAIL mapped_total got=%0d want=%0d", ov_discard_total, m_total); end
  endtask

  task automatic test_std_discard();
    default_cfg();
    m_lp = 20;
    set_pkt(1'b0, 0, 60, 20, 16'h0800);
    p_abort_at = 7; p_trunc = 1'b0;
    apply_cfg();
    send_pkt(); model_pkt();
    for (int j = 0; j < ncyc; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin errors++; $display("FAIL std_disc_cyc%0d got=%h want=%h", j, obs[j], expv[j]); end
    end
    iv_cnt_sel = 3'd6; #1;
    checks++;
    if (ov_discard_cnt !== CW'(1)) begin errors++; $display("FAIL std_disc_cnt6 got=%0d want=1", ov_discard_cnt); end
    checks++;
    if (ov_discard_total !== CW'(1)) begin errors++; $display("FAIL std_disc_total got=%0d want=1", ov_discard_total); end
  endtask

  task automatic test_std_short();
    default_cfg();
    set_pkt(1'b0, 0, 10, 200, 16'h88f7);
    apply_cfg();
    send_pkt(); model_pkt();
    for (int j = 0; j < ncyc; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin errors++; $display("FAIL std_short_cyc%0d got=%h want=%h", j, obs[j], expv[j]); end
    end
  endtask

  task automatic test_class_disable_clr();
    default_cfg();
    m_en[2] = 1'b0;
    set_pkt(1'b1, 2, 8, 200, 16'h1800);
    p_clr = 1'b1;
    apply_cfg();
    send_pkt(); model_pkt();
    for (int j = 0; j < ncyc; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin errors++; $display("FAIL cls_dis_cyc%0d got=%h want=%h", j, obs[j], expv[j]); end
    end
    iv_cnt_sel = 3'd2; #1;
    checks++;
    if (ov_discard_cnt !== CW'(1)) begin errors++; $display("FAIL cls_dis_cnt2 got=%0d want=1", ov_discard_cnt); end
    iv_cnt_sel = 3'd6; #1;
    checks++;
    if (ov_discard_cnt !== '0) begin errors++; $display("FAIL cls_dis_cnt6 got=%0d want=0", ov_discard_cnt); end
    checks++;
    if (ov_discard_total !== CW'(1)) begin errors++; $display("FAIL cls_dis_total got=%0d want=1", ov_discard_total); end
  endtask

  task automatic test_abort();
    default_cfg();
    set_pkt(1'b0, 0, 30, 200, 16'h0800);
    p_abort_at = 5; p_trunc = 1'b1; p_clr = 1'b1; p_idle = 0;
    apply_cfg();
    send_pkt(); model_pkt();
    for (int j = 0; j < ncyc; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin errors++; $display("FAIL abort_cyc%0d got=%h want=%h", j, obs[j], expv[j]); end
    end
    checks++;
    if (ov_abort_cnt !== CW'(1)) begin errors++; $display("FAIL abort_cnt got=%0d want=1", ov_abort_cnt); end
    set_pkt(1'b1, 5, 12, 200, 16'h1800);
    apply_cfg();
    send_pkt(); model_pkt();
    for (int j = 0; j < ncyc; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin errors++; $display("FAIL after_abort_cyc%0d got=%h want=%h", j, obs[j], expv[j]); end
    end
  endtask

  task automatic test_saturation();
    default_cfg();
    for (int n = 0; n < 17; n++) begin
      set_pkt(1'b0, 0, 4, 5, 16'h0800);
      p_clr = (n == 0); p_idle = 0;
      apply_cfg();
      send_pkt(); model_pkt();
      for (int j = 0; j < ncyc; j++) begin
        checks++;
        if (obs[j] !== expv[j]) begin errors++; $display("FAIL sat_pkt%0d_cyc%0d got=%h want=%h", n, j, obs[j], expv[j]); end
      end
    end
    iv_cnt_sel = 3'd6; #1;
    checks++;
    if (ov_discard_cnt !== CW'(CMAX)) begin errors++; $display("FAIL sat_cnt6 got=%0d want=%0d", ov_discard_cnt, CMAX); end
    checks++;
    if (ov_discard_total !== CW'(CMAX)) begin errors++; $display("FAIL sat_total got=%0d want=%0d", ov_discard_total, CMAX); end
  endtask

  task automatic test_async_reset_mid();
    obs_t o;
    default_cfg();
    set_pkt(1'b1, 1, 20, 200, 16'h1800);
    apply_cfg();
    iv_tsntag = p_tag; iv_eth_type = p_eth;
    for (int i = 0; i < 3; i++) begin
      iv_data   = (i == 0) ? {1'b1, 3'd1, 5'($urandom)} : {1'b0, 8'($urandom)};
      i_data_wr = 1'b1;
      @(posedge i_clk); #1;
    end
    checks++;
    if (o_data_wr !== 1'b1) begin errors++; $display("FAIL rst_mid_fwd got=%b want=1", o_data_wr); end
    #2 i_rst_n = 1'b0;
    #1 o = sample();
    iv_cnt_sel = 3'd6; #0;
    checks++;
    if (o !== '0) begin errors++; $display("FAIL rst_mid_outputs got=%h want=0", o); end
    checks++;
    if (ov_discard_total !== '0 || ov_discard_cnt !== '0) begin
      errors++; $display("FAIL rst_mid_counters got=%0d/%0d want=0/0", ov_discard_total, ov_discard_cnt);
    end
    model_zero_counters();
    #2 i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv_data   = {1'b0, 8'($urandom)};
      i_data_wr = 1'b1;
      @(posedge i_clk); #1;
      o = sample();
      checks++;
      if (o !== '0) begin errors++; $display("FAIL rst_residual%0d got=%h want=0", i, o); end
    end
    i_data_wr = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_random_back_to_back();
    bit disc;
    int k, sel;
    for (int n = 0; n < 60; n++) begin
      for (int c = 0; c < 8; c++) m_thr[c] = $urandom_range(0, 300);
      m_ctrl = $urandom_range(0, 300);
      m_lp   = $urandom_range(0, 300);
      m_en   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hff;
      if ($urandom_range(0, 1) == 1) begin
        set_pkt(1'b1, $urandom_range(0, 7), $urandom_range(3, 40), 0, 16'h1800);
      end else begin
        k = $urandom_range(0, 4);
        set_pkt(1'b0, 0, $urandom_range(2, 40), 0, (k < 4) ? eth_tab[k] : 16'($urandom));
        if (p_eth == 16'h1800) p_eth = 16'h0801;
      end
      p_free = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 511);
      disc = model_discard();
      p_abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, p_len - 1) : 0;
      p_trunc = !disc;
      p_clr   = ($urandom_range(0, 9) == 0);
      p_idle  = $urandom_range(0, 2);
      apply_cfg();
      send_pkt(); model_pkt();
      for (int j = 0; j < ncyc; j++) begin
        checks++;
        if (obs[j] !== expv[j]) begin errors++; $display("FAIL rnd_pkt%0d_cyc%0d got=%h want=%h", n, j, obs[j], expv[j]); end
      end
      sel = $urandom_range(0, 7);
      iv_cnt_sel = 3'(sel); #1;
      checks++;
      if (ov_discard_cnt !== CW'(m_disc[sel])) begin errors++; $display("FAIL rnd_cnt%0d pkt%0d got=%0d want=%0d", sel, n, ov_discard_cnt, m_disc[sel]); end
      checks++;
      if (ov_discard_total !== CW'(m_total)) begin errors++; $display("FAIL rnd_total pkt%0d got=%0d want=%0d", n, ov_discard_total, m_total); end
      checks++;
      if (ov_abort_cnt !== CW'(m_abort)) begin errors++; $display("FAIL rnd_abort pkt%0d got=%0d want=%0d", n, ov_abort_cnt, m_abort); end
    end
  endtask

  initial begin
    default_cfg();
    model_zero_counters();
    test_reset();
    test_mapped();
    test_std_discard();
    test_std_short();
    test_class_disable_clr();
    test_abort();
    test_saturation();
    test_async_reset_mid();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
